// File: rtl/inorder_alloc_issue_queue.sv
// In-order reservation-station controller: busy bits, tail (allocate) and head (issue) pointers, occupancy count.
// Optional same-cycle reuse of the issuing entry is enabled by defining INORDER_FREE_BYPASS_EN.
module inorder_alloc_issue_queue #(
  parameter int ENT_SEL    = 2,
  parameter int ENT_NUM    = 1 << ENT_SEL,
  parameter int DISP_WIDTH = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [1:0]         req_num_i,
  input  logic               dp_stall_i,
  input  logic               dp_kill_i,
  input  logic [ENT_NUM-1:0] ready_vector_i,
  input  logic               issue_ack_i,
  output logic [ENT_SEL-1:0] alloc_ptr_o,
  output logic               allocatable_o,
  output logic [ENT_SEL-1:0] issue_ptr_o,
  output logic               issue_valid_o,
  output logic [ENT_NUM-1:0] busy_vector_o,
  output logic [ENT_SEL:0]   count_o
);

  localparam int CNT_W  = ENT_SEL + 1;
  localparam int FREE_W = ENT_SEL + 2;

  logic [ENT_SEL-1:0] head_q, tail_q;
  logic [ENT_NUM-1:0] busy_q;
  logic [CNT_W-1:0]   count_q;

  logic [ENT_SEL-1:0] head_n, tail_n, set_idx;
  logic [ENT_NUM-1:0] busy_n;
  logic [CNT_W-1:0]   count_n;
  logic [FREE_W-1:0]  free_slots;
  logic               req_in_range;
  logic               alloc_fire;
  logic               issue_fire;

  // Issue handshake: issue_valid_o is offered combinationally for the head entry;
  // the entry leaves the queue on a rising edge where issue_valid_o & issue_ack_i,
  // and issue_valid_o never waits on issue_ack_i.
  assign issue_valid_o = busy_q[head_q] & ready_vector_i[head_q] & ~dp_kill_i;
  assign issue_fire    = issue_valid_o & issue_ack_i;

`ifdef INORDER_FREE_BYPASS_EN
  assign free_slots = FREE_W'(ENT_NUM) - FREE_W'(count_q) + FREE_W'(issue_fire);
`else
  assign free_slots = FREE_W'(ENT_NUM) - FREE_W'(count_q);
`endif

  assign req_in_range  = int'(req_num_i) <= DISP_WIDTH;
  assign allocatable_o = ~reset_i & req_in_range & (FREE_W'(req_num_i) <= free_slots);
  assign alloc_fire    = allocatable_o & ~dp_stall_i & ~dp_kill_i & (req_num_i != 2'd0);

  assign alloc_ptr_o   = tail_q;
  assign issue_ptr_o   = head_q;
  assign busy_vector_o = busy_q;
  assign count_o       = count_q;

  // Issue clears first so a same-index allocation (bypass build, full queue) keeps the bit set.
  always_comb begin
    busy_n  = busy_q;
    head_n  = head_q;
    tail_n  = tail_q;
    count_n = count_q;
    set_idx = tail_q;
    if (dp_kill_i) begin
      busy_n  = '0;
      head_n  = '0;
      tail_n  = '0;
      count_n = '0;
    end else begin
      if (issue_fire) begin
        busy_n[head_q] = 1'b0;
        head_n         = head_q + ENT_SEL'(1);
      end
      if (alloc_fire) begin
        for (int k = 0; k < DISP_WIDTH; k++) begin
          if (k < int'(req_num_i)) begin
            set_idx         = tail_q + ENT_SEL'(k);
            busy_n[set_idx] = 1'b1;
          end
        end
        tail_n = tail_q + ENT_SEL'(req_num_i);
      end
      count_n = count_q + (alloc_fire ? CNT_W'(req_num_i) : CNT_W'(0)) - CNT_W'(issue_fire);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      busy_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_n;
      head_q  <= head_n;
      tail_q  <= tail_n;
      count_q <= count_n;
    end
  end

endmodule

// File: tb/tb_inorder_alloc_issue_queue.sv
// Directed, table-driven bench for inorder_alloc_issue_queue (ENT_SEL=2, DISP_WIDTH=2).
module tb_inorder_alloc_issue_queue;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [1:0] req_num_i;
  logic       dp_stall_i;
  logic       dp_kill_i;
  logic [3:0] ready_vector_i;
  logic       issue_ack_i;
  logic [1:0] alloc_ptr_o;
  logic       allocatable_o;
  logic [1:0] issue_ptr_o;
  logic       issue_valid_o;
  logic [3:0] busy_vector_o;
  logic [2:0] count_o;

  int errors = 0;
  int checks = 0;
  logic [2:0] exp_q[$];

  inorder_alloc_issue_queue #(.ENT_SEL(2), .DISP_WIDTH(2)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .req_num_i      (req_num_i),
    .dp_stall_i     (dp_stall_i),
    .dp_kill_i      (dp_kill_i),
    .ready_vector_i (ready_vector_i),
    .issue_ack_i    (issue_ack_i),
    .alloc_ptr_o    (alloc_ptr_o),
    .allocatable_o  (allocatable_o),
    .issue_ptr_o    (issue_ptr_o),
    .issue_valid_o  (issue_valid_o),
    .busy_vector_o  (busy_vector_o),
    .count_o        (count_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0] req;
    logic       stall;
    logic       kill;
    logic [3:0] ready;
    logic       ack;
    logic       e_ok;
    logic       e_iv;
    logic [1:0] e_iptr;
    logic [1:0] e_aptr;
    logic [3:0] e_busy;
    logic [2:0] e_cnt;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic stall, input logic kill,
                       input logic [3:0] ready, input logic ack);
    req_num_i      = req;
    dp_stall_i     = stall;
    dp_kill_i      = kill;
    ready_vector_i = ready;
    issue_ack_i    = ack;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".alloc_ptr"},   32'(alloc_ptr_o),   32'd0);
    check({tag, ".issue_ptr"},   32'(issue_ptr_o),   32'd0);
    check({tag, ".busy"},        32'(busy_vector_o), 32'd0);
    check({tag, ".count"},       32'(count_o),       32'd0);
    check({tag, ".issue_valid"}, 32'(issue_valid_o), 32'd0);
    check({tag, ".allocatable"}, 32'(allocatable_o), 32'd0);
  endtask

  initial begin
    //            req   st    kl    ready    ack   ok    iv    iptr   aptr   busy     cnt
    vecs[0]  = '{2'd0, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 4'b0000, 3'd0};
    vecs[1]  = '{2'd2, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 4'b0000, 3'd0};
    vecs[2]  = '{2'd0, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b1, 2'd0, 2'd2, 4'b0011, 3'd2};
    vecs[3]  = '{2'd0, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b0, 2'd1, 2'd2, 4'b0010, 3'd1};
    vecs[4]  = '{2'd3, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd1, 2'd2, 4'b0010, 3'd1};
    vecs[5]  = '{2'd2, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b1, 2'd1, 2'd2, 4'b0010, 3'd1};
    vecs[6]  = '{2'd1, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 2'd2, 2'd2, 4'b0000, 3'd0};
    vecs[7]  = '{2'd2, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd2, 2'd3, 4'b0100, 3'd1};
    vecs[8]  = '{2'd1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd2, 2'd1, 4'b1101, 3'd3};
    vecs[9]  = '{2'd1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 4'b1111, 3'd4};
    vecs[10] = '{2'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd2, 2'd2, 4'b1111, 3'd4};
`ifdef INORDER_FREE_BYPASS_EN
    vecs[11] = '{2'd1, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b1, 1'b1, 2'd2, 2'd2, 4'b1111, 3'd4};
    vecs[12] = '{2'd2, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd3, 2'd3, 4'b1111, 3'd4};
`else
    vecs[11] = '{2'd1, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 2'd2, 4'b1111, 3'd4};
    vecs[12] = '{2'd2, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd3, 2'd2, 4'b1011, 3'd3};
`endif
    vecs[13] = '{2'd0, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 4'b0000, 3'd0};

    // reset state, checked while reset is still high
    reset_i = 1'b1;
    drive(2'd0, 1'b0, 1'b0, 4'b0000, 1'b0);
    #2;
    check_all_zero("reset");
    @(negedge clk_i);
    reset_i = 1'b0;

    // vector table: drive on the falling edge, check 1ns later, state advances on the next rising edge
    for (int i = 0; i < NVEC; i++) begin
      if (i != 0) @(negedge clk_i);
      drive(vecs[i].req, vecs[i].stall, vecs[i].kill, vecs[i].ready, vecs[i].ack);
      exp_q.push_back(vecs[i].e_cnt);
      #1;
      check($sformatf("v%0d.allocatable", i), 32'(allocatable_o), 32'(vecs[i].e_ok));
      check($sformatf("v%0d.issue_valid", i), 32'(issue_valid_o), 32'(vecs[i].e_iv));
      check($sformatf("v%0d.issue_ptr", i),   32'(issue_ptr_o),   32'(vecs[i].e_iptr));
      check($sformatf("v%0d.alloc_ptr", i),   32'(alloc_ptr_o),   32'(vecs[i].e_aptr));
      check($sformatf("v%0d.busy", i),        32'(busy_vector_o), 32'(vecs[i].e_busy));
      check($sformatf("v%0d.count", i),       32'(count_o),       32'(exp_q.pop_front()));
    end

    // asynchronous reset mid-run with count = 3
    @(negedge clk_i);
    drive(2'd2, 1'b0, 1'b0, 4'b0000, 1'b0);
    @(negedge clk_i);
    drive(2'd1, 1'b0, 1'b0, 4'b0000, 1'b0);
    @(negedge clk_i);
    drive(2'd1, 1'b0, 1'b0, 4'b0000, 1'b0);
    #1;
    check("mid.count_before", 32'(count_o),       32'd3);
    check("mid.busy_before",  32'(busy_vector_o), 32'b0111);
    #1;
    reset_i = 1'b1;
    #1;
    check_all_zero("async_reset");
    #1;
    reset_i = 1'b0;
    #1;
    check("post_reset.allocatable", 32'(allocatable_o), 32'd1);

    // req_num_i = 3 rejected even when empty
    drive(2'd3, 1'b0, 1'b0, 4'b0000, 1'b0);
    #1;
    check("req3_empty.allocatable", 32'(allocatable_o), 32'd0);
    @(negedge clk_i);
    check("req3_empty.count", 32'(count_o), 32'd0);
    drive(2'd0, 1'b0, 1'b0, 4'b0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/inorder_alloc_issue_queue.md
# inorder_alloc_issue_queue

Parametrised in-order reservation-station controller. It owns the busy state, the allocate (tail) pointer and the issue (head) pointer for a circular entry array. It accepts up to DISP_WIDTH allocations per cycle from dispatch and issues the oldest entry once its operands are ready. It sits between the dispatch stage and one in-order functional-unit queue, and drives the write index and read index of the entry RAM. Unlike the single-issue-width predecessor, it tracks occupancy internally, exposes a count, and has an issue acknowledge. A kill flushes the whole queue.

## Interface
- ENT_SEL, 2, entry index width.
- ENT_NUM, 1<<ENT_SEL, entry count; must be a power of two.
- DISP_WIDTH, 2, maximum allocations per cycle; legal range 1..3.
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  reset; asynchronous, active-high.
- req_num_i  in  2  number of entries dispatch requests this cycle.
- dp_stall_i  in  1  dispatch stalled; suppresses allocation.
- dp_kill_i  in  1  pipeline flush; empties the queue.
- ready_vector_i  in  ENT_NUM  per-entry operands-ready flags from the wakeup logic.
- issue_ack_i  in  1  functional unit accepts the issued entry.
- alloc_ptr_o  out  ENT_SEL  index of the first entry allocated this cycle (the tail).
- allocatable_o  out  1  the current request fits.
- issue_ptr_o  out  ENT_SEL  index of the oldest entry (the head).
- issue_valid_o  out  1  head entry is busy and ready.
- busy_vector_o  out  ENT_NUM  per-entry occupied flags.
- count_o  out  ENT_SEL+1  number of busy entries, 0..ENT_NUM.

## Operation
- State:
  - head and tail pointers, ENT_SEL bits each, wrapping modulo ENT_NUM.
  - busy register, ENT_NUM bits.
  - count register, ENT_SEL+1 bits.
- free = ENT_NUM - count.
- allocatable_o:
  - 0 while reset_i is high.
  - 0 if req_num_i > DISP_WIDTH.
  - Otherwise 1 when req_num_i <= free.
  - Always 1 when req_num_i = 0.
- alloc_fire = allocatable_o & ~dp_stall_i & ~dp_kill_i & (req_num_i != 0).
- On alloc_fire:
  - set busy[tail + k] for k = 0..req_num_i-1, modulo ENT_NUM.
  - tail advances by req_num_i, modulo ENT_NUM.
- issue_valid_o = busy[head] & ready_vector_i[head] & ~dp_kill_i.
- issue_ptr_o = head, always; it is meaningful only when issue_valid_o = 1.
- issue_fire = issue_valid_o & issue_ack_i.
- On issue_fire: clear busy[head]; head advances by 1, modulo ENT_NUM.
- count next value = count + (alloc_fire ? req_num_i : 0) - (issue_fire ? 1 : 0).
- Alloc and issue in the same cycle are independent. When both touch the same entry, the set of busy wins (legal only with the macro below).
- dp_kill_i has priority over everything:
  - next state is busy = 0, head = tail = 0, count = 0.
  - no alloc_fire and no issue_fire occur in the kill cycle.
- dp_stall_i does not block issue.

## Timing
- Reset values: alloc_ptr_o = 0, issue_ptr_o = 0, busy_vector_o = 0, count_o = 0, issue_valid_o = 0, allocatable_o = 0.
- Reset takes effect immediately (asynchronous), not at the next clock edge.
- allocatable_o and issue_valid_o are combinational from the current state and inputs of the same cycle.
- Latency:
  - An entry allocated at edge N is busy from cycle N+1.
  - It can issue in cycle N+1 at the earliest.
- Full boundary: count = ENT_NUM means no allocation of size 1 or more (except via the bypass below).
- Empty boundary: count = 0 forces issue_valid_o = 0, whatever ready_vector_i holds.
- Wrap-around: with tail = ENT_NUM-1 and req_num_i = 2, the entries ENT_NUM-1 and 0 are set, and tail becomes 1.

## Configuration
- INORDER_FREE_BYPASS_EN:
  - Defined: free = ENT_NUM - count + issue_fire. An entry freed by this cycle's issue is reusable on the same edge.
    - This creates a combinational path from ready_vector_i and issue_ack_i to allocatable_o.
    - When a full queue allocates 1 and issues in the same cycle, the busy bit at the shared index stays 1 and count is unchanged.
  - Undefined: free = ENT_NUM - count. allocatable_o depends only on registered state, req_num_i and reset_i.

## Test plan
All scenarios use ENT_SEL = 2 and DISP_WIDTH = 2.
- Reset mid-run: with count = 3, assert reset_i between clock edges -> all outputs go to 0 immediately, with no edge needed.
- Alloc of 2 from empty with ready_vector_i = 4'b0001, issue_ack_i = 1 -> cycle+1: busy = 0011, count = 2, issue_valid_o = 1, issue_ptr_o = 0; cycle+2: busy = 0010, head = 1, count = 1.
- Wrap: with tail = 3, head = 3, count = 0, alloc 2 -> busy = 1001, alloc_ptr_o = 1, count = 2; issuing in order gives issue_ptr_o = 3 then 0.
- Full: after 4 allocations, req_num_i = 1 -> allocatable_o = 0, and neither busy nor alloc_ptr_o changes. req_num_i = 3 is rejected at any count.
- Kill: with count = 3, assert dp_kill_i together with req_num_i = 2 and issue_ack_i = 1 -> issue_valid_o = 0 in that cycle; next cycle busy = 0, pointers = 0, count = 0.
- Bypass: full queue, head ready, issue_ack_i = 1, req_num_i = 1:
  - with INORDER_FREE_BYPASS_EN defined -> allocatable_o = 1, count stays 4, head and tail both advance.
  - with it undefined -> allocatable_o = 0 and count becomes 3.
